// File: rtl/mux_scan_pkg.sv
// Shared constants and types for the mux scan sequencer.
// The sequencer walks the four channels of a 4:1 mux.
package mux_scan_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // A one-cycle dwell still needs a 1-bit counter so the port widths stay legal.
    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 multiplexer whose select lines are driven by the scan sequencer.
// y follows sel combinationally.
module mux_4_1 (
    input  logic [1:0] sel,
    input  logic [3:0] in,
    output logic       y
);

    assign y = in[sel];

endmodule

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled.
// last flags the sample cycle of the current channel.
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int              CNT_W    = cnt_width(DWELL);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == LAST_VAL);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps mux select through channels 0..3, samples y_in at the end of each dwell,
// and delivers the 4-bit snapshot over a valid/ready handshake.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    output logic [SEL_W-1:0] sel,
    input  logic             y_in,
    output logic [N_CH-1:0]  snap,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [N_CH-1:0]  shadow_q, shadow_d;
    logic [N_CH-1:0]  snap_q, snap_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;

    logic             dwell_last;
    logic             accept;
    logic             sample;
    logic             frame_end;
    logic             drop;
    logic [N_CH-1:0]  frame_word;

    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == IDLE),
        .en    (state_q == SCAN),
        .last  (dwell_last)
    );

    assign accept    = valid_q & snap_ready;
    assign sample    = (state_q == SCAN) & dwell_last;
    assign frame_end = sample & (ch_q == LAST_CH);

    // The word handed downstream must include the bit captured on this very edge.
    always_comb begin
        frame_word       = shadow_q;
        frame_word[ch_q] = y_in;
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        valid_d  = valid_q & ~accept;
        ovr_d    = ovr_q;
        drop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    ch_d    = '0;
                end
            end
            SCAN: begin
                if (sample) begin
                    shadow_d = frame_word;
                    ch_d     = ch_q + 1'b1;
                    if (frame_end) begin
                        if (!valid_q || accept) begin
                            snap_d  = frame_word;
                            valid_d = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                        if (!cont) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh drop outranks a clear on the same edge.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end

        busy_d = (state_d == SCAN);
    end

    // NOTE: the shadow register is reset like any other flop; it is only four bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            shadow_q <= '0;
            snap_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sel        = ch_q;
    assign snap       = snap_q;
    assign snap_valid = valid_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: three instances (DWELL=1,2,3) share stimulus and are
// compared every cycle against a frame-position model, plus directed literal checks.
module tb_mux_scan_sequencer;

    localparam int N_INST = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       snap_ready;
    logic       ovr_clr;
    logic [3:0] in_vec;

    logic [1:0] sel_w   [N_INST];
    logic       y_w     [N_INST];
    logic [3:0] snap_w  [N_INST];
    logic       valid_w [N_INST];
    logic       busy_w  [N_INST];
    logic       ovr_w   [N_INST];

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        mux_4_1 u_mux (
            .sel (sel_w[g]),
            .in  (in_vec),
            .y   (y_w[g])
        );
        mux_scan_sequencer #(
            .DWELL (g + 1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .cont       (cont),
            .sel        (sel_w[g]),
            .y_in       (y_w[g]),
            .snap       (snap_w[g]),
            .snap_valid (valid_w[g]),
            .snap_ready (snap_ready),
            .busy       (busy_w[g]),
            .overrun    (ovr_w[g]),
            .ovr_clr    (ovr_clr)
        );
    end

    // Model: a scan is a run of 4*D cycles indexed by position p; sel = p/D,
    // sample when p%D == D-1, frame ends at p == 4*D-1.
    bit       m_busy   [N_INST];
    int       m_pos    [N_INST];
    bit [3:0] m_shadow [N_INST];
    bit [3:0] m_snap   [N_INST];
    bit       m_valid  [N_INST];
    bit       m_ovr    [N_INST];

    always @(posedge clk) begin
        int d;
        int ch;
        bit acc;
        bit drop;
        for (int i = 0; i < N_INST; i++) begin
            d = i + 1;
            if (!rst_n) begin
                m_busy[i]   = 1'b0;
                m_pos[i]    = 0;
                m_shadow[i] = 4'b0;
                m_snap[i]   = 4'b0;
                m_valid[i]  = 1'b0;
                m_ovr[i]    = 1'b0;
            end else begin
                acc  = m_valid[i] && snap_ready;
                drop = 1'b0;
                if (acc) m_valid[i] = 1'b0;
                if (m_busy[i]) begin
                    ch = m_pos[i] / d;
                    if (m_pos[i] % d == d - 1) m_shadow[i][ch] = in_vec[ch];
                    if (m_pos[i] == 4 * d - 1) begin
                        if (!m_valid[i]) begin
                            m_snap[i]  = m_shadow[i];
                            m_valid[i] = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                        m_pos[i] = 0;
                        if (!cont) m_busy[i] = 1'b0;
                    end else begin
                        m_pos[i] = m_pos[i] + 1;
                    end
                end else if (start) begin
                    m_busy[i] = 1'b1;
                    m_pos[i]  = 0;
                end
                if (drop) m_ovr[i] = 1'b1;
                else if (ovr_clr) m_ovr[i] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < N_INST; i++) begin
                check("model_sel",   i, 32'(sel_w[i]),   m_busy[i] ? 32'(m_pos[i] / (i + 1)) : 32'd0);
                check("model_snap",  i, 32'(snap_w[i]),  32'(m_snap[i]));
                check("model_valid", i, 32'(valid_w[i]), 32'(m_valid[i]));
                check("model_busy",  i, 32'(busy_w[i]),  32'(m_busy[i]));
                check("model_ovr",   i, 32'(ovr_w[i]),   32'(m_ovr[i]));
            end
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string name, input int inst);
        check({name, "_sel"},   inst, 32'(sel_w[inst]),   32'd0);
        check({name, "_snap"},  inst, 32'(snap_w[inst]),  32'd0);
        check({name, "_valid"}, inst, 32'(valid_w[inst]), 32'd0);
        check({name, "_busy"},  inst, 32'(busy_w[inst]),  32'd0);
        check({name, "_ovr"},   inst, 32'(ovr_w[inst]),   32'd0);
    endtask

    logic [1:0] exp_sel [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

    initial begin
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; snap_ready = 1'b0;
        ovr_clr = 1'b0; in_vec = 4'b0;
        step(2);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        for (int i = 0; i < N_INST; i++) check_reset_outputs("por", i);

        // Single shot, DWELL=2 (instance 1).
        in_vec = 4'b1010; cont = 1'b0; snap_ready = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("t1_sel",   1, 32'(sel_w[1]),   32'(exp_sel[c-1]));
            check("t1_busy",  1, 32'(busy_w[1]),  32'd1);
            check("t1_valid", 1, 32'(valid_w[1]), 32'd0);
            step(1);
        end
        check("t1_valid9", 1, 32'(valid_w[1]), 32'd1);
        check("t1_snap9",  1, 32'(snap_w[1]),  32'hA);
        check("t1_busy9",  1, 32'(busy_w[1]),  32'd0);
        check("t1_model",  1, 32'(m_snap[1]),  32'hA);
        step(1);
        check("t1_valid10", 1, 32'(valid_w[1]), 32'd0);
        check("t1_sel10",   1, 32'(sel_w[1]),   32'd0);
        step(4);

        // Continuous, DWELL=1 (instance 0).
        in_vec = 4'b0110; cont = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        check("t2_snap_a",  0, 32'(snap_w[0]),  32'h6);
        check("t2_valid_a", 0, 32'(valid_w[0]), 32'd1);
        in_vec = 4'b1001;
        step(4);
        check("t2_snap_b",  0, 32'(snap_w[0]),  32'h9);
        check("t2_valid_b", 0, 32'(valid_w[0]), 32'd1);
        check("t2_ovr",     0, 32'(ovr_w[0]),   32'd0);
        cont = 1'b0;
        step(30);

        // Overrun with a stalled consumer, DWELL=2.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_reset_outputs("t3_rst", 1);
        in_vec = 4'b1010; cont = 1'b1; snap_ready = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(8);
        check("t3_snap9",  1, 32'(snap_w[1]),  32'hA);
        check("t3_valid9", 1, 32'(valid_w[1]), 32'd1);
        in_vec = 4'b0101;
        step(8);
        check("t3_ovr17",  1, 32'(ovr_w[1]),   32'd1);
        check("t3_snap17", 1, 32'(snap_w[1]),  32'hA);
        snap_ready = 1'b1;
        step(1);
        check("t3_valid18", 1, 32'(valid_w[1]), 32'd0);
        snap_ready = 1'b0; ovr_clr = 1'b1;
        step(1);
        check("t3_ovr19", 1, 32'(ovr_w[1]), 32'd0);
        ovr_clr = 1'b0; cont = 1'b0;
        step(30);

        // Ready on the frame-end edge reloads without overrun, then reset mid-scan.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        in_vec = 4'b1010; cont = 1'b1; snap_ready = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(8);
        check("t4_snap9", 1, 32'(snap_w[1]), 32'hA);
        in_vec = 4'b0110;
        step(7);
        snap_ready = 1'b1;
        step(1);
        check("t4_valid17", 1, 32'(valid_w[1]), 32'd1);
        check("t4_snap17",  1, 32'(snap_w[1]),  32'h6);
        check("t4_ovr17",   1, 32'(ovr_w[1]),   32'd0);
        snap_ready = 1'b0; cont = 1'b0;
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < N_INST; i++) check_reset_outputs("t5_rst", i);
        snap_ready = 1'b1; in_vec = 4'b1010; start = 1'b1;
        step(1);
        start = 1'b0;
        step(7);
        check("t5_valid8", 1, 32'(valid_w[1]), 32'd0);
        step(1);
        check("t5_valid9", 1, 32'(valid_w[1]), 32'd1);
        check("t5_snap9",  1, 32'(snap_w[1]),  32'hA);
        step(6);

        // start held through a whole single-shot frame.
        in_vec = 4'b0011; cont = 1'b0; snap_ready = 1'b1; start = 1'b1;
        step(9);
        start = 1'b0;
        check("t6_valid9", 1, 32'(valid_w[1]), 32'd1);
        check("t6_snap9",  1, 32'(snap_w[1]),  32'h3);
        check("t6_busy9",  1, 32'(busy_w[1]),  32'd0);
        step(3);
        check("t6_busy12",  1, 32'(busy_w[1]),  32'd0);
        check("t6_valid12", 1, 32'(valid_w[1]), 32'd0);
        step(10);

        // Randomized traffic, checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            start      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) cont = ~cont;
            snap_ready = ($urandom_range(0, 3) != 0);
            ovr_clr    = ($urandom_range(0, 15) == 0);
            in_vec     = 4'($urandom);
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
